// File: rtl/snn_syn_pkg.sv
// Shared definitions for the synaptic SRAM arbiter slice.
//   syn_state_e      : arbiter states (IDLE, UPD_RD, UPD_WR)
//   SYN_WEIGHT_WIDTH : default signed weight width
//   SYN_DATA_WIDTH   : default SRAM word width
//   SYN_LANES        : default weight lanes per SRAM word
//   syn_lanes()      : lanes per word for a given word/weight width
package snn_syn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_RD = 2'd1,
    UPD_WR = 2'd2
  } syn_state_e;

  localparam int unsigned SYN_WEIGHT_WIDTH = 8;
  localparam int unsigned SYN_DATA_WIDTH   = 32;
  localparam int unsigned SYN_LANES        = SYN_DATA_WIDTH / SYN_WEIGHT_WIDTH;

  function automatic int unsigned syn_lanes(input int unsigned dw, input int unsigned ww);
    return dw / ww;
  endfunction

endpackage

// File: rtl/syn_sat_add.sv
// Lane-wise signed saturating adder (purely combinational).
//   a_i   : packed signed lanes (old weights)
//   b_i   : packed signed lanes (deltas)
//   sum_o : per-lane a+b clamped to [-2^(W-1), 2^(W-1)-1]
module syn_sat_add
  import snn_syn_pkg::*;
#(
  parameter int unsigned WEIGHT_WIDTH = SYN_WEIGHT_WIDTH,
  parameter int unsigned LANES        = SYN_LANES
) (
  input  logic [LANES*WEIGHT_WIDTH-1:0] a_i,
  input  logic [LANES*WEIGHT_WIDTH-1:0] b_i,
  output logic [LANES*WEIGHT_WIDTH-1:0] sum_o
);

  logic [WEIGHT_WIDTH-1:0] lane_a;
  logic [WEIGHT_WIDTH-1:0] lane_b;
  logic [WEIGHT_WIDTH:0]   lane_ext;
  logic [WEIGHT_WIDTH-1:0] lane_r;

  always_comb begin
    sum_o    = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_ext = '0;
    lane_r   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_a   = a_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      lane_b   = b_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      lane_ext = {lane_a[WEIGHT_WIDTH-1], lane_a} + {lane_b[WEIGHT_WIDTH-1], lane_b};
      // Overflow when the extra sign bit disagrees with the lane sign bit;
      // the extra bit then tells which rail to clamp to.
      if (lane_ext[WEIGHT_WIDTH] != lane_ext[WEIGHT_WIDTH-1]) begin
        lane_r = lane_ext[WEIGHT_WIDTH] ? {1'b1, {(WEIGHT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
      end else begin
        lane_r = lane_ext[WEIGHT_WIDTH-1:0];
      end
      sum_o[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = lane_r;
    end
  end

endmodule

// File: rtl/sram_syn_arbiter.sv
// Arbitrates the single-port synaptic weight SRAM between inference reads
// and learning read-modify-write updates (signed saturating per-lane add).
// Optional feature macro: SYN_STARVE_GUARD_EN (update forced after
// STARVE_LIMIT consecutive denied IDLE cycles; strict read priority otherwise).
// Ports:
//   CK, RSTN                     : clock, async active-low reset
//   RD_REQ/RD_ADDR -> RD_GNT     : inference read request / grant (comb)
//   RD_VLD/RD_DATA               : read data, one cycle after RD_GNT
//   UPD_REQ/UPD_ADDR/UPD_DELTA   : update request with packed lane deltas
//   UPD_GNT/UPD_DONE/BUSY        : update grant, write-cycle pulse, RMW busy
//   SRAM_CS/WE/A/D, SRAM_Q       : macro pins (Q registered, 1-cycle latency)
module sram_syn_arbiter
  import snn_syn_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = SYN_DATA_WIDTH,
  parameter int unsigned WEIGHT_WIDTH = SYN_WEIGHT_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  CK,
  input  logic                  RSTN,
  input  logic                  RD_REQ,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic                  RD_GNT,
  output logic                  RD_VLD,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  UPD_REQ,
  input  logic [ADDR_WIDTH-1:0] UPD_ADDR,
  input  logic [DATA_WIDTH-1:0] UPD_DELTA,
  output logic                  UPD_GNT,
  output logic                  UPD_DONE,
  output logic                  BUSY,
  output logic                  SRAM_CS,
  output logic                  SRAM_WE,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [DATA_WIDTH-1:0] SRAM_D,
  input  logic [DATA_WIDTH-1:0] SRAM_Q
);

  localparam int unsigned LANES = syn_lanes(DATA_WIDTH, WEIGHT_WIDTH);

  syn_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] delta_q, delta_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] sat_sum;
  logic                  force_upd;

  syn_sat_add #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .LANES        (LANES)
  ) u_sat_add (
    .a_i   (SRAM_Q),
    .b_i   (delta_q),
    .sum_o (sat_sum)
  );

`ifdef SYN_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign force_upd = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts IDLE cycles in which a pending update lost to a read.
  always_comb begin
    starve_d = starve_q;
    if (UPD_GNT) begin
      starve_d = '0;
    end else if (state_q == IDLE && UPD_REQ && !force_upd) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_upd = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    delta_d  = delta_q;
    wdata_d  = wdata_q;
    RD_GNT   = 1'b0;
    UPD_GNT  = 1'b0;
    UPD_DONE = 1'b0;
    SRAM_CS  = 1'b0;
    SRAM_WE  = 1'b0;
    SRAM_A   = '0;
    SRAM_D   = '0;
    unique case (state_q)
      IDLE: begin
        if (RD_REQ && !(UPD_REQ && force_upd)) begin
          RD_GNT  = 1'b1;
          SRAM_CS = 1'b1;
          SRAM_A  = RD_ADDR;
        end else if (UPD_REQ) begin
          UPD_GNT = 1'b1;
          SRAM_CS = 1'b1;
          SRAM_A  = UPD_ADDR;
          addr_d  = UPD_ADDR;
          delta_d = UPD_DELTA;
          state_d = UPD_RD;
        end
      end
      UPD_RD: begin
        wdata_d = sat_sum;
        state_d = UPD_WR;
      end
      UPD_WR: begin
        SRAM_CS  = 1'b1;
        SRAM_WE  = 1'b1;
        SRAM_A   = addr_q;
        SRAM_D   = wdata_q;
        UPD_DONE = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      delta_q  <= '0;
      wdata_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      delta_q  <= delta_d;
      wdata_q  <= wdata_d;
      rd_vld_q <= RD_GNT;
    end
  end

  assign RD_VLD  = rd_vld_q;
  assign RD_DATA = SRAM_Q;
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_sram_syn_arbiter.sv
// Self-checking bench for sram_syn_arbiter with a behavioural SRAM macro
// and a transaction-level reference model of the arbiter.
module tb_sram_syn_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int WW = 8;
  localparam int LN = DW / WW;
  localparam int SL = 4;

  logic          CK = 1'b0;
  logic          RSTN = 1'b0;
  logic          RD_REQ = 1'b0;
  logic [AW-1:0] RD_ADDR = '0;
  logic          RD_GNT, RD_VLD;
  logic [DW-1:0] RD_DATA;
  logic          UPD_REQ = 1'b0;
  logic [AW-1:0] UPD_ADDR = '0;
  logic [DW-1:0] UPD_DELTA = '0;
  logic          UPD_GNT, UPD_DONE, BUSY;
  logic          SRAM_CS, SRAM_WE;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] SRAM_D;
  logic [DW-1:0] SRAM_Q = '0;

  sram_syn_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .WEIGHT_WIDTH (WW),
    .STARVE_LIMIT (SL)
  ) dut (
    .CK        (CK),
    .RSTN      (RSTN),
    .RD_REQ    (RD_REQ),
    .RD_ADDR   (RD_ADDR),
    .RD_GNT    (RD_GNT),
    .RD_VLD    (RD_VLD),
    .RD_DATA   (RD_DATA),
    .UPD_REQ   (UPD_REQ),
    .UPD_ADDR  (UPD_ADDR),
    .UPD_DELTA (UPD_DELTA),
    .UPD_GNT   (UPD_GNT),
    .UPD_DONE  (UPD_DONE),
    .BUSY      (BUSY),
    .SRAM_CS   (SRAM_CS),
    .SRAM_WE   (SRAM_WE),
    .SRAM_A    (SRAM_A),
    .SRAM_D    (SRAM_D),
    .SRAM_Q    (SRAM_Q)
  );

  always #5 CK = ~CK;

  // Behavioural SRAM macro: registered read, write on CS&WE.
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge CK) begin
    if (SRAM_CS) begin
      if (SRAM_WE) mem[SRAM_A] <= SRAM_D;
      else         SRAM_Q      <= mem[SRAM_A];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference lane arithmetic: integer add, then clamp to the signed range.
  function automatic logic [DW-1:0] m_satadd(input logic [DW-1:0] w, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LN; i++) begin
      logic signed [WW-1:0] la, lb;
      int s;
      la = w[i*WW +: WW];
      lb = d[i*WW +: WW];
      s  = int'(la) + int'(lb);
      if (s >  (2**(WW-1)) - 1) s =  (2**(WW-1)) - 1;
      if (s < -(2**(WW-1)))     s = -(2**(WW-1));
      r[i*WW +: WW] = s[WW-1:0];
    end
    return r;
  endfunction

  // Model: m_upd_age = cycles elapsed since the update grant (0 = none in flight).
  int            m_upd_age = 0;
  int            m_starve  = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_delta;
  logic [DW-1:0] m_new;
  logic          m_vld = 1'b0;
  logic [DW-1:0] m_vld_data;
  logic          m_rd_gnt_last  = 1'b0;
  logic          m_upd_gnt_last = 1'b0;
  int            dut_rd_gnt_cnt  = 0;
  int            dut_upd_gnt_cnt = 0;
  int            dut_we_cnt      = 0;
  int            dut_done_cnt    = 0;

  // Single compare process; inputs change only at posedge+2, so at negedge
  // they are stable for the cycle being checked.
  always @(negedge CK) begin
    logic e_rd_gnt, e_upd_gnt, e_cs, e_we, e_done, e_busy, forced;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    if (!RSTN) begin
      chk("rst_rd_vld",  RD_VLD,   1'b0);
      chk("rst_busy",    BUSY,     1'b0);
      chk("rst_done",    UPD_DONE, 1'b0);
      chk("rst_cs",      SRAM_CS,  1'b0);
      chk("rst_we",      SRAM_WE,  1'b0);
      chk("rst_rd_gnt",  RD_GNT,   1'b0);
      chk("rst_upd_gnt", UPD_GNT,  1'b0);
      m_upd_age = 0; m_starve = 0; m_vld = 1'b0;
      m_rd_gnt_last = 1'b0; m_upd_gnt_last = 1'b0;
    end else begin
      e_rd_gnt = 0; e_upd_gnt = 0; e_cs = 0; e_we = 0; e_done = 0;
      e_a = '0; e_d = '0;
      e_busy = (m_upd_age != 0);
      if (m_upd_age == 0) begin
`ifdef SYN_STARVE_GUARD_EN
        forced = (m_starve >= SL);
`else
        forced = 1'b0;
`endif
        if (UPD_REQ && (!RD_REQ || forced)) begin
          e_upd_gnt = 1; e_cs = 1; e_a = UPD_ADDR;
          m_addr = UPD_ADDR; m_delta = UPD_DELTA; m_starve = 0;
        end else begin
          if (RD_REQ) begin
            e_rd_gnt = 1; e_cs = 1; e_a = RD_ADDR;
          end
          if (UPD_REQ) m_starve++;
        end
      end else if (m_upd_age == 1) begin
        m_new = m_satadd(ref_mem[m_addr], m_delta);
      end else begin
        e_cs = 1; e_we = 1; e_done = 1; e_a = m_addr; e_d = m_new;
      end

      chk("rd_gnt",  RD_GNT,   e_rd_gnt);
      chk("upd_gnt", UPD_GNT,  e_upd_gnt);
      chk("busy",    BUSY,     e_busy);
      chk("done",    UPD_DONE, e_done);
      chk("cs",      SRAM_CS,  e_cs);
      chk("we",      SRAM_WE,  e_we);
      chk("rd_vld",  RD_VLD,   m_vld);
      if (e_cs) chk("sram_a", SRAM_A, e_a);
      if (e_we) chk("sram_d", SRAM_D, e_d);
      if (m_vld) chk("rd_data", RD_DATA, m_vld_data);

      if (RD_GNT)   dut_rd_gnt_cnt++;
      if (UPD_GNT)  dut_upd_gnt_cnt++;
      if (SRAM_WE)  dut_we_cnt++;
      if (UPD_DONE) dut_done_cnt++;

      // Advance the model to the next cycle.
      if (m_upd_age == 2) ref_mem[m_addr] = m_new;
      m_vld = e_rd_gnt;
      if (e_rd_gnt) m_vld_data = ref_mem[RD_ADDR];
      if (e_upd_gnt)           m_upd_age = 1;
      else if (m_upd_age == 1) m_upd_age = 2;
      else if (m_upd_age == 2) m_upd_age = 0;
      m_rd_gnt_last  = e_rd_gnt;
      m_upd_gnt_last = e_upd_gnt;
    end
  end

  task automatic step();
    @(posedge CK);
    #2;
  endtask

  initial begin
    int c0, c1, c2, first_gnt;
    logic [DW-1:0] old20;
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] v;
      v = $urandom;
      mem[i] = v; ref_mem[i] = v;
    end
    mem[9]  = 32'h0010807E; ref_mem[9]  = 32'h0010807E;
    mem[20] = 32'h12345678; ref_mem[20] = 32'h12345678;
    repeat (3) @(posedge CK);
    #2 RSTN = 1'b1;
    step();

    // Starvation: read held constantly alongside an update request.
    RD_REQ = 1'b1; RD_ADDR = 8'd1;
    UPD_REQ = 1'b1; UPD_ADDR = 8'd7; UPD_DELTA = 32'h01FF7F80;
    first_gnt = 0;
    c0 = dut_upd_gnt_cnt;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (first_gnt == 0 && dut_upd_gnt_cnt != c0) first_gnt = k;
      if (m_upd_gnt_last) UPD_REQ = 1'b0;
    end
`ifdef SYN_STARVE_GUARD_EN
    chk("starve_first_gnt", first_gnt, 5);
`else
    chk("starve_first_gnt", first_gnt, 0);
`endif
    RD_REQ = 1'b0;
    step();
    if (m_upd_gnt_last) UPD_REQ = 1'b0;
    repeat (3) step();

    // Reads only: addresses 0..3 on consecutive cycles.
    c0 = dut_rd_gnt_cnt; c1 = dut_we_cnt;
    for (int i = 0; i < 4; i++) begin
      RD_REQ = 1'b1; RD_ADDR = AW'(i);
      step();
    end
    RD_REQ = 1'b0;
    step();
    chk("reads_gnt_cnt", dut_rd_gnt_cnt - c0, 4);
    chk("reads_we_cnt",  dut_we_cnt - c1, 0);

    // Single RMW with saturation in both directions.
    c0 = dut_done_cnt; c1 = dut_we_cnt;
    UPD_REQ = 1'b1; UPD_ADDR = 8'd9; UPD_DELTA = 32'h0001F005;
    step();
    UPD_REQ = 1'b0;
    repeat (3) step();
    chk("rmw_mem9",     mem[9], 32'h0011807F);
    chk("rmw_done_cnt", dut_done_cnt - c0, 1);
    chk("rmw_we_cnt",   dut_we_cnt - c1, 1);

    // Contention, read blocked during RMW, read-after-update on address 5.
    c0 = dut_rd_gnt_cnt;
    RD_REQ = 1'b1; RD_ADDR = 8'd3;
    UPD_REQ = 1'b1; UPD_ADDR = 8'd5; UPD_DELTA = 32'h7F80017F;
    step();                       // read wins
    RD_REQ = 1'b0;
    step();                       // update granted
    UPD_REQ = 1'b0; RD_REQ = 1'b1; RD_ADDR = 8'd5;
    step();                       // UPD_RD: no read grant
    step();                       // UPD_WR: no read grant
    step();                       // IDLE: read of 5 granted
    RD_REQ = 1'b0;
    step();
    chk("cont_rd_gnt_cnt", dut_rd_gnt_cnt - c0, 2);
    chk("cont_mem5", mem[5], m_satadd(32'h0, 32'h0) ^ ref_mem[5]);

    // Reset in UPD_RD aborts the write.
    old20 = mem[20]; c2 = dut_we_cnt;
    UPD_REQ = 1'b1; UPD_ADDR = 8'd20; UPD_DELTA = 32'h01010101;
    step();
    UPD_REQ = 1'b0; RSTN = 1'b0;
    step();
    step();
    RSTN = 1'b1;
    repeat (2) step();
    chk("rst_mem20", mem[20], 32'h12345678);
    chk("rst_mem20_old", mem[20], old20);
    chk("rst_we_cnt", dut_we_cnt - c2, 0);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 3000; n++) begin
      if (!RD_REQ || m_rd_gnt_last) begin
        RD_REQ  = ($urandom_range(0, 2) != 0);
        RD_ADDR = AW'($urandom_range(0, 15));
      end
      if (!UPD_REQ || m_upd_gnt_last) begin
        UPD_REQ   = ($urandom_range(0, 3) == 0);
        UPD_ADDR  = AW'($urandom_range(0, 15));
        UPD_DELTA = $urandom;
      end
      step();
    end
    RD_REQ = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (m_upd_gnt_last) UPD_REQ = 1'b0;
      step();
    end
    UPD_REQ = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
